// File: rtl/dcache_refill_arbiter.sv
// dcache_refill_arbiter: shares the L1 DCache data-array refill write port among N_REQ MSHRs,
// granting one MSHR round-robin and locking the port for a full block of BEATS rows.
// Optional build macro DCACHE_REFILL_PERF_EN adds saturating refill/stall counters.
module dcache_refill_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BEATS     = 4,
  parameter int IDX_BITS  = 6,
  parameter int WAY_BITS  = 3,
  parameter int DATA_BITS = 128,
  localparam int ROW_BITS = $clog2(BEATS),
  localparam int OWN_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*IDX_BITS-1:0]     req_idx,
  input  logic [N_REQ*WAY_BITS-1:0]     req_way,
  input  logic [N_REQ-1:0]              beat_valid,
  input  logic [N_REQ*DATA_BITS-1:0]    beat_data,
  output logic [N_REQ-1:0]              beat_ready,
  output logic [N_REQ-1:0]              done,
  output logic                          arr_wen,
  input  logic                          arr_ready,
  output logic [IDX_BITS-1:0]           arr_idx,
  output logic [WAY_BITS-1:0]           arr_way,
  output logic [ROW_BITS-1:0]           arr_row,
  output logic [DATA_BITS-1:0]          arr_data,
  output logic                          busy,
  output logic [OWN_BITS-1:0]           owner
`ifdef DCACHE_REFILL_PERF_EN
  ,
  output logic [31:0]                   perf_refills,
  output logic [31:0]                   perf_stalls
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(BEATS - 1);

  state_t                state_q, state_d;
  logic [OWN_BITS-1:0]   rr_q, rr_d;
  logic [ROW_BITS-1:0]   cnt_q, cnt_d;
  logic [OWN_BITS-1:0]   own_q, own_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [WAY_BITS-1:0]   way_q, way_d;

  logic                  pick_vld;
  logic [OWN_BITS-1:0]   pick;
  logic [OWN_BITS-1:0]   rr_next;
  logic                  fire;

  // Requester number base+ofs modulo N_REQ; both operands are below N_REQ.
  function automatic logic [OWN_BITS-1:0] wrap_idx(input logic [OWN_BITS-1:0] base,
                                                   input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return OWN_BITS'(sum);
  endfunction

  // Round-robin search: first pending requester at or after rr_ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(rr_q, k)]) begin
        pick_vld = 1'b1;
        pick     = wrap_idx(rr_q, k);
      end
    end
  end

  // Pointer moves just past the owner whether the block finished or was aborted.
  assign rr_next = wrap_idx(own_q, 1);

  // Next-state and output decode; port outputs stay zero outside BURST/DONE.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    own_d      = own_q;
    idx_d      = idx_q;
    way_d      = way_q;
    fire       = 1'b0;
    beat_ready = '0;
    done       = '0;
    arr_wen    = 1'b0;
    arr_idx    = '0;
    arr_way    = '0;
    arr_row    = '0;
    arr_data   = '0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          own_d   = pick;
          idx_d   = req_idx[int'(pick)*IDX_BITS +: IDX_BITS];
          way_d   = req_way[int'(pick)*WAY_BITS +: WAY_BITS];
          cnt_d   = '0;
          state_d = S_BURST;
        end
      end

      S_BURST: begin
        arr_idx           = idx_q;
        arr_way           = way_q;
        arr_row           = cnt_q;
        arr_data          = beat_data[int'(own_q)*DATA_BITS +: DATA_BITS];
        // The array drops a write presented while arr_ready is low, so the
        // enable follows the beat alone and only the handshake advances rows.
        arr_wen           = beat_valid[own_q];
        beat_ready[own_q] = arr_ready;
        fire              = beat_valid[own_q] & arr_ready;
        if (!req_valid[own_q]) begin
          // Owner withdrew: release the port, no completion, rows stay written.
          rr_d    = rr_next;
          state_d = S_IDLE;
        end else if (fire) begin
          cnt_d = cnt_q + ROW_BITS'(1);
          if (cnt_q == LAST_ROW) state_d = S_DONE;
        end
      end

      S_DONE: begin
        // req_valid is not looked at here, so the finisher cannot be re-granted.
        done[own_q] = 1'b1;
        rr_d        = rr_next;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Arbiter state and the registered grant (owner, set index, way, row counter).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      own_q   <= '0;
      idx_q   <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign owner = own_q;

`ifdef DCACHE_REFILL_PERF_EN
  logic stall;
  assign stall = (state_q == S_BURST) && beat_valid[own_q] && !arr_ready;

  // Saturating counters: completed refills and beats held off by the core.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_refills <= '0;
      perf_stalls  <= '0;
    end else begin
      if ((state_q == S_DONE) && (perf_refills != '1)) perf_refills <= perf_refills + 32'd1;
      if (stall && (perf_stalls != '1))                perf_stalls  <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_refill_arbiter.sv
// tb_dcache_refill_arbiter: directed scenarios followed by randomized traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_dcache_refill_arbiter;

  localparam int N     = 4;
  localparam int BEATS = 4;
  localparam int IW    = 6;
  localparam int WW    = 3;
  localparam int DW    = 128;
  localparam int RW    = 2;
  localparam int OW    = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, beat_valid, beat_ready, done;
  logic [N*IW-1:0]   req_idx;
  logic [N*WW-1:0]   req_way;
  logic [N*DW-1:0]   beat_data;
  logic              arr_wen, arr_ready, busy;
  logic [IW-1:0]     arr_idx;
  logic [WW-1:0]     arr_way;
  logic [RW-1:0]     arr_row;
  logic [DW-1:0]     arr_data;
  logic [OW-1:0]     owner;
`ifdef DCACHE_REFILL_PERF_EN
  logic [31:0]       perf_refills, perf_stalls;
`endif

  dcache_refill_arbiter #(
    .N_REQ(N), .BEATS(BEATS), .IDX_BITS(IW), .WAY_BITS(WW), .DATA_BITS(DW)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_idx(req_idx), .req_way(req_way),
    .beat_valid(beat_valid), .beat_data(beat_data), .beat_ready(beat_ready),
    .done(done), .arr_wen(arr_wen), .arr_ready(arr_ready),
    .arr_idx(arr_idx), .arr_way(arr_way), .arr_row(arr_row), .arr_data(arr_data),
    .busy(busy), .owner(owner)
`ifdef DCACHE_REFILL_PERF_EN
    , .perf_refills(perf_refills), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Requester-side state: each MSHR's block, victim slot and beats handed over.
  logic [DW-1:0] blk [N][BEATS];
  logic [IW-1:0] idx_m [N];
  logic [WW-1:0] way_m [N];
  int            sent [N];
  logic [N-1:0]  acc, dn;
  bit            rnd_mode = 0;
  logic [N-1:0]  bv_force = '0;

  // Reference model: current refill transaction and round-robin pointer.
  int ph = 0;       // 0 no refill, 1 rows streaming, 2 completion cycle
  int m_own = 0, m_rr = 0, m_rows = 0, cyc = 0, n_done = 0;
  int g_own[$], g_cyc[$], d_cyc[$];
  logic [N-1:0] sb_oh;

  always @(negedge clock) begin
    cyc++;
    acc = beat_valid & beat_ready;
    dn  = done;
    if (reset) begin
      ph = 0; m_rr = 0; m_rows = 0;
      check("rst_busy", busy, 0);
      check("rst_wen", arr_wen, 0);
      check("rst_rdy", beat_ready, 0);
      check("rst_done", done, 0);
    end else begin
      sb_oh = '0;
      sb_oh[m_own] = 1'b1;
      case (ph)
        0: begin
          check("idle_busy", busy, 0);
          check("idle_wen", arr_wen, 0);
          check("idle_rdy", beat_ready, 0);
          check("idle_done", done, 0);
          if (req_valid != '0) begin
            for (int k = 0; k < N; k++) begin
              if (req_valid[(m_rr + k) % N]) begin
                m_own = (m_rr + k) % N;
                break;
              end
            end
            ph = 1; m_rows = 0;
            g_own.push_back(m_own);
            g_cyc.push_back(cyc);
          end
        end
        1: begin
          check("burst_busy", busy, 1);
          check("burst_owner", owner, m_own);
          check("burst_rdy", beat_ready, arr_ready ? sb_oh : '0);
          check("burst_wen", arr_wen, beat_valid[m_own]);
          check("burst_done", done, 0);
          if (beat_valid[m_own]) begin
            check("row", arr_row, m_rows);
            check("idx", arr_idx, idx_m[m_own]);
            check("way", arr_way, way_m[m_own]);
            check("data", arr_data, blk[m_own][m_rows]);
          end
          if (!req_valid[m_own]) begin
            ph = 0; m_rr = (m_own + 1) % N;
          end else if (beat_valid[m_own] && arr_ready) begin
            m_rows++;
            if (m_rows == BEATS) ph = 2;
          end
        end
        default: begin
          check("done_vec", done, sb_oh);
          check("done_busy", busy, 1);
          check("done_wen", arr_wen, 0);
          check("done_rdy", beat_ready, 0);
          ph = 0; m_rr = (m_own + 1) % N;
          d_cyc.push_back(cyc);
          n_done++;
        end
      endcase
    end
  end

  task automatic new_req(input int i, input logic [IW-1:0] ix, input logic [WW-1:0] wy);
    req_valid[i] = 1'b1;
    idx_m[i] = ix; way_m[i] = wy; sent[i] = 0;
    req_idx[i*IW +: IW] = ix;
    req_way[i*WW +: WW] = wy;
    for (int b = 0; b < BEATS; b++) blk[i][b] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic rand_drive();
    arr_ready = ($urandom_range(3) != 0);
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && $urandom_range(7) == 0) new_req(i, IW'($urandom), WW'($urandom));
      beat_valid[i] = (req_valid[i] && sent[i] < BEATS) ? ($urandom_range(3) != 0)
                                                        : ($urandom_range(7) == 0);
    end
    if (ph == 1 && $urandom_range(63) == 0) begin
      req_valid[m_own]  = 1'b0;
      beat_valid[m_own] = 1'b0;
    end
  endtask

  // One clock: requesters react to the last handshake, then present new inputs.
  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) sent[i]++;
      if (dn[i]) req_valid[i] = 1'b0;
    end
    if (rnd_mode) rand_drive();
    else for (int i = 0; i < N; i++) beat_valid[i] = bv_force[i] | (req_valid[i] && sent[i] < BEATS);
    for (int i = 0; i < N; i++) beat_data[i*DW +: DW] = blk[i][sent[i] % BEATS];
  endtask

  task automatic clear_logs();
    g_own.delete(); g_cyc.delete(); d_cyc.delete();
  endtask

  int nd0;
`ifdef DCACHE_REFILL_PERF_EN
  int pr0, ps0;
`endif

  initial begin
    reset = 1'b1; req_valid = '0; beat_valid = '0; arr_ready = 1'b1;
    req_idx = '0; req_way = '0; beat_data = '0;
    for (int i = 0; i < N; i++) begin
      sent[i] = 0; idx_m[i] = '0; way_m[i] = '0;
      for (int b = 0; b < BEATS; b++) blk[i][b] = '0;
    end
    step(); step();
    check("rst_owner", owner, 0);
    check("rst_row", arr_row, 0);
    check("rst_data", arr_data, 0);
    reset = 1'b0;
    step();

    // Round-robin with all four pending: order 0,1,2,3, one grant every BEATS+2 cycles.
    clear_logs();
    for (int i = 0; i < N; i++) new_req(i, IW'(i * 9 + 1), WW'(7 - i));
    repeat (30) step();
    check("rr_count", g_own.size(), 4);
    for (int k = 0; k < 4 && k < g_own.size(); k++) check("rr_order", g_own[k], k);
    for (int k = 0; k < 3 && k + 1 < g_cyc.size(); k++) check("rr_spacing", g_cyc[k+1] - g_cyc[k], BEATS + 2);

    // Single refill for MSHR2 at idx 0x2A way 5.
    clear_logs();
    new_req(2, 6'h2A, 3'd5);
    repeat (10) step();
    check("single_count", g_own.size(), 1);
    if (g_own.size() > 0) check("single_owner", g_own[0], 2);
    if (d_cyc.size() > 0 && g_cyc.size() > 0) check("single_latency", d_cyc[0] - g_cyc[0], BEATS + 1);
    else check("single_done_seen", d_cyc.size(), 1);

    // Pointer now sits at 3, so MSHR0 wins over MSHR1 after the wrap.
    clear_logs();
    new_req(0, 6'h11, 3'd1);
    new_req(1, 6'h22, 3'd2);
    repeat (16) step();
    check("wrap_count", g_own.size(), 2);
    if (g_own.size() == 2) begin
      check("wrap_first", g_own[0], 0);
      check("wrap_second", g_own[1], 1);
    end

    // Back-pressure: core holds the array on the beat_cnt=1 and beat_cnt=2 cycles.
    clear_logs();
`ifdef DCACHE_REFILL_PERF_EN
    pr0 = perf_refills; ps0 = perf_stalls;
`endif
    new_req(3, 6'h3C, 3'd6);
    for (int k = 0; k < 12; k++) begin
      step();
      arr_ready = !(k == 1 || k == 3);
    end
    arr_ready = 1'b1;
    if (d_cyc.size() > 0 && g_cyc.size() > 0) check("bp_latency", d_cyc[0] - g_cyc[0], BEATS + 3);
    else check("bp_done_seen", d_cyc.size(), 1);
`ifdef DCACHE_REFILL_PERF_EN
    check("perf_refills", perf_refills - pr0, 1);
    check("perf_stalls", perf_stalls - ps0, 2);
`endif

    // Abort with a non-owner streaming beats: MSHR1 withdraws after two rows.
    clear_logs();
    nd0 = n_done;
    bv_force = 4'b0001;
    new_req(1, 6'h05, 3'd3);
    step();
    for (int k = 0; k < 20 && m_rows < 2; k++) step();
    check("abort_rows", m_rows, 2);
    req_valid[1] = 1'b0;
    beat_valid[1] = 1'b0;
    repeat (4) step();
    check("abort_no_done", n_done - nd0, 0);
    check("abort_idle", busy, 0);
    bv_force = '0;
    clear_logs();
    new_req(0, 6'h01, 3'd0);
    new_req(2, 6'h02, 3'd4);
    repeat (16) step();
    check("abort_next_count", g_own.size(), 2);
    if (g_own.size() == 2) begin
      check("abort_next_first", g_own[0], 2);
      check("abort_next_second", g_own[1], 0);
    end

    // Async reset in the middle of a burst at beat_cnt=2.
    new_req(3, 6'h15, 3'd2);
    step();
    for (int k = 0; k < 20 && m_rows < 2; k++) step();
    check("rstmid_rows", m_rows, 2);
    #2 reset = 1'b1;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_wen", arr_wen, 0);
    check("rstmid_rdy", beat_ready, 0);
    check("rstmid_owner", owner, 0);
    check("rstmid_idx", arr_idx, 0);
    check("rstmid_row", arr_row, 0);
    req_valid = '0; beat_valid = '0;
    for (int i = 0; i < N; i++) sent[i] = 0;
    step(); step();
    reset = 1'b0;
    clear_logs();
    new_req(0, 6'h0A, 3'd1);
    new_req(3, 6'h3F, 3'd7);
    repeat (16) step();
    check("postrst_count", g_own.size(), 2);
    if (g_own.size() == 2) begin
      check("postrst_first", g_own[0], 0);
      check("postrst_second", g_own[1], 3);
    end

    // Randomized traffic, stalls and occasional aborts.
    nd0 = n_done;
    rnd_mode = 1;
    repeat (4000) step();
    rnd_mode = 0;
    check("rnd_progress", (n_done - nd0) > 20, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
